// File: rtl/pipelined_shifter_if.sv
// Handshake bundle for pipelined_shifter: issue side (in_*), result side (out_*) and flush.
interface pipelined_shifter_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_op;
  logic [WIDTH-1:0]   in_src;
  logic [SHAMT_W-1:0] in_shamt;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output flush, in_valid, in_op, in_src, in_shamt, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  flush, in_valid, in_op, in_src, in_shamt, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter/rotator: log-shift levels spread over STAGES register stages
// with a valid/ready handshake, backpressure, flush and a pass-through tag.
module pipelined_shifter #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input logic                clk,
  input logic                rst,
  pipelined_shifter_if.slave bus
);
  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  localparam int unsigned BASE    = SHAMT_W / STAGES;
  localparam int unsigned REM     = SHAMT_W % STAGES;

  // First shift level handled by stage s; earlier stages absorb the remainder.
  function automatic int unsigned lvl_lo(input int unsigned s);
    return s * BASE + ((s < REM) ? s : REM);
  endfunction

  function automatic logic [WIDTH-1:0] shift_level(input logic [2:0] op,
                                                   input logic [WIDTH-1:0] d,
                                                   input int unsigned amt);
    logic [WIDTH-1:0] r;
    case (op)
      3'b000:  r = d << amt;
      3'b001:  r = d >> amt;
      3'b010:  r = $signed(d) >>> amt;
      3'b011:  r = (d << amt) | (d >> (WIDTH - amt));
      3'b100:  r = (d >> amt) | (d << (WIDTH - amt));
      default: r = d;
    endcase
    return r;
  endfunction

  logic in_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    localparam int unsigned LO   = lvl_lo(s);
    localparam int unsigned HI   = lvl_lo(s + 1);
    localparam bit          LAST = (s == STAGES - 1);

    logic               v_in;
    logic [WIDTH-1:0]   d_in;
    logic [2:0]         op_in;
    logic [SHAMT_W-1:LO] sh_in;
    logic [TAG_W-1:0]   tag_in;
    logic               adv, nxt_adv, load;
    logic               valid_d, valid_q;
    logic [WIDTH-1:0]   data_d, data_q;
    logic [TAG_W-1:0]   tag_q;

    if (s == 0) begin : g_src
      assign v_in   = bus.in_valid & in_ready;
      assign d_in   = bus.in_src;
      assign op_in  = bus.in_op;
      assign sh_in  = bus.in_shamt;
      assign tag_in = bus.in_tag;
    end else begin : g_src
      assign v_in   = g_stage[s-1].valid_q;
      assign d_in   = g_stage[s-1].data_q;
      assign op_in  = g_stage[s-1].g_carry.op_q;
      assign sh_in  = g_stage[s-1].g_carry.shamt_q;
      assign tag_in = g_stage[s-1].tag_q;
    end

    if (LAST) begin : g_adv
      assign nxt_adv = bus.out_ready;
    end else begin : g_adv
      assign nxt_adv = g_stage[s+1].adv;
    end

    assign adv     = ~valid_q | nxt_adv;
    assign load    = adv & v_in & ~bus.flush;
    assign valid_d = bus.flush ? 1'b0 : (adv ? v_in : valid_q);

    always_comb begin
      data_d = d_in;
      for (int unsigned k = LO; k < HI; k++) begin
        if (sh_in[k]) data_d = shift_level(op_in, data_d, 32'd1 << k);
      end
    end

    // Data/tag only load with a real op, so the last stage holds its result when empty.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else begin
        valid_q <= valid_d;
        if (load) begin
          data_q <= data_d;
          tag_q  <= tag_in;
        end
      end
    end

    // Op and the not-yet-applied shamt bits only exist where a later stage consumes them.
    if (!LAST) begin : g_carry
      logic [2:0]          op_q;
      logic [SHAMT_W-1:HI] shamt_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          op_q    <= '0;
          shamt_q <= '0;
        end else if (load) begin
          op_q    <= op_in;
          shamt_q <= sh_in[SHAMT_W-1:HI];
        end
      end
    end
  end

  assign in_ready      = ~rst & ~bus.flush & g_stage[0].adv;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = g_stage[STAGES-1].valid_q;
  assign bus.out_data  = g_stage[STAGES-1].data_q;
  assign bus.out_tag   = g_stage[STAGES-1].tag_q;
endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed and sweep bench for pipelined_shifter (main instance STAGES=2, sweep STAGES=1/3/5).
module tb_pipelined_shifter;
  logic clk;
  logic rst;

  int errors = 0;
  int checks = 0;

  pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) sb ();
  pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) s1 ();
  pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) s3 ();
  pipelined_shifter_if #(.WIDTH(32), .TAG_W(5)) s5 ();

  pipelined_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut   (.clk(clk), .rst(rst), .bus(sb));
  pipelined_shifter #(.WIDTH(32), .STAGES(1), .TAG_W(5)) dut_1 (.clk(clk), .rst(rst), .bus(s1));
  pipelined_shifter #(.WIDTH(32), .STAGES(3), .TAG_W(5)) dut_3 (.clk(clk), .rst(rst), .bus(s3));
  pipelined_shifter #(.WIDTH(32), .STAGES(5), .TAG_W(5)) dut_5 (.clk(clk), .rst(rst), .bus(s5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] src;
    logic [4:0]  sh;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  logic [36:0] q1[$];
  logic [36:0] q3[$];
  logic [36:0] q5[$];

  logic        w_valid;
  logic [2:0]  w_op;
  logic [31:0] w_src;
  logic [4:0]  w_sh;
  logic [4:0]  w_tag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      3'd0:    r = a << sh;
      3'd1:    r = a >> sh;
      3'd2:    r = $signed(a) >>> sh;
      3'd3:    r = (a << sh) | (a >> (32 - int'(sh)));
      3'd4:    r = (a >> sh) | (a << (32 - int'(sh)));
      default: r = a;
    endcase
    return r;
  endfunction

  task automatic drive_main(input logic v, input logic [2:0] op, input logic [31:0] src,
                            input logic [4:0] sh, input logic [4:0] tag);
    sb.in_valid = v;
    sb.in_op    = op;
    sb.in_src   = src;
    sb.in_shamt = sh;
    sb.in_tag   = tag;
  endtask

  task automatic check_out(input string name, input logic [31:0] d, input logic [4:0] t);
    check({name, "_valid"}, 32'(sb.out_valid), 32'd1);
    check({name, "_data"}, sb.out_data, d);
    check({name, "_tag"}, 32'(sb.out_tag), 32'(t));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_drive();
    s1.in_valid = w_valid; s1.in_op = w_op; s1.in_src = w_src; s1.in_shamt = w_sh; s1.in_tag = w_tag;
    s3.in_valid = w_valid; s3.in_op = w_op; s3.in_src = w_src; s3.in_shamt = w_sh; s3.in_tag = w_tag;
    s5.in_valid = w_valid; s5.in_op = w_op; s5.in_src = w_src; s5.in_shamt = w_sh; s5.in_tag = w_tag;
  endtask

  task automatic sweep_chk(input int id, input logic ov, input logic [31:0] od,
                           input logic [4:0] ot, input logic ir);
    logic [36:0] e;
    logic        have;
    have = 1'b0;
    e    = '0;
    if (ov) begin
      case (id)
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        3: if (q3.size() > 0) begin e = q3.pop_front(); have = 1'b1; end
        default: if (q5.size() > 0) begin e = q5.pop_front(); have = 1'b1; end
      endcase
      if (!have) check($sformatf("sweep_s%0d_extra", id), 32'd1, 32'd0);
      else begin
        check($sformatf("sweep_s%0d_data", id), od, e[31:0]);
        check($sformatf("sweep_s%0d_tag", id), 32'(ot), 32'(e[36:32]));
      end
    end
    if (w_valid && ir) begin
      e = {w_tag, model(w_op, w_src, w_sh)};
      case (id)
        1: q1.push_back(e);
        3: q3.push_back(e);
        default: q5.push_back(e);
      endcase
    end
  endtask

  logic [2:0]  st_op [6];
  logic [31:0] st_src[6];
  logic [4:0]  st_sh [6];
  logic [4:0]  st_tag[6];

  initial begin
    int issued, got;
    logic held_v, bp_seen;
    logic [31:0] held_d;
    logic [4:0]  held_t;

    vecs[0]  = '{3'b010, 32'h80000000, 5'd31, 5'd1,  32'hFFFFFFFF};
    vecs[1]  = '{3'b001, 32'h80000000, 5'd31, 5'd2,  32'h00000001};
    vecs[2]  = '{3'b100, 32'h12345678, 5'd8,  5'd3,  32'h78123456};
    vecs[3]  = '{3'b011, 32'h12345678, 5'd4,  5'd4,  32'h23456781};
    vecs[4]  = '{3'b000, 32'h0000FFFF, 5'd16, 5'd5,  32'hFFFF0000};
    vecs[5]  = '{3'b000, 32'hDEADBEEF, 5'd0,  5'd6,  32'hDEADBEEF};
    vecs[6]  = '{3'b001, 32'hDEADBEEF, 5'd0,  5'd7,  32'hDEADBEEF};
    vecs[7]  = '{3'b010, 32'hDEADBEEF, 5'd0,  5'd8,  32'hDEADBEEF};
    vecs[8]  = '{3'b011, 32'hDEADBEEF, 5'd0,  5'd9,  32'hDEADBEEF};
    vecs[9]  = '{3'b100, 32'hDEADBEEF, 5'd0,  5'd10, 32'hDEADBEEF};
    vecs[10] = '{3'b111, 32'hDEADBEEF, 5'd13, 5'd11, 32'hDEADBEEF};
    vecs[11] = '{3'b101, 32'hDEADBEEF, 5'd7,  5'd12, 32'hDEADBEEF};
    vecs[12] = '{3'b010, 32'h7000000F, 5'd4,  5'd13, 32'h07000000};
    vecs[13] = '{3'b011, 32'h80000001, 5'd1,  5'd14, 32'h00000003};
    vecs[14] = '{3'b000, 32'h00000001, 5'd31, 5'd15, 32'h80000000};
    vecs[15] = '{3'b100, 32'h00000001, 5'd31, 5'd16, 32'h00000002};
    vecs[16] = '{3'b010, 32'hF0000000, 5'd3,  5'd17, 32'hFE000000};

    rst = 1'b1;
    sb.flush = 1'b0; sb.out_ready = 1'b1;
    drive_main(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
    w_valid = 1'b0; w_op = '0; w_src = '0; w_sh = '0; w_tag = '0;
    s1.flush = 1'b0; s3.flush = 1'b0; s5.flush = 1'b0;
    s1.out_ready = 1'b1; s3.out_ready = 1'b1; s5.out_ready = 1'b1;
    sweep_drive();

    // Reset state
    tick();
    check("rst_in_ready", 32'(sb.in_ready), 32'd0);
    check("rst_out_valid", 32'(sb.out_valid), 32'd0);
    check("rst_out_data", sb.out_data, 32'd0);
    check("rst_out_tag", 32'(sb.out_tag), 32'd0);
    tick();
    rst = 1'b0;
    #1;

    // Table: back-to-back issue, result of vector i-1 visible after the edge accepting i
    for (int i = 0; i < NV; i++) begin
      drive_main(1'b1, vecs[i].op, vecs[i].src, vecs[i].sh, vecs[i].tag);
      #1;
      check($sformatf("vec%0d_in_ready", i), 32'(sb.in_ready), 32'd1);
      tick();
      if (i == 0) check("latency_not_yet", 32'(sb.out_valid), 32'd0);
      else check_out($sformatf("vec%0d", i - 1), vecs[i-1].exp, vecs[i-1].tag);
    end
    drive_main(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
    tick();
    check_out($sformatf("vec%0d", NV - 1), vecs[NV-1].exp, vecs[NV-1].tag);
    tick();
    check("table_drained", 32'(sb.out_valid), 32'd0);

    // Backpressure: 6 ops, consumer stalls in cycles 3..5
    for (int i = 0; i < 6; i++) begin
      st_op[i]  = 3'(i % 5);
      st_src[i] = 32'hA5A5_0F0F + 32'(i) * 32'h0111_1111;
      st_sh[i]  = 5'(3 * i + 1);
      st_tag[i] = 5'(20 + i);
    end
    issued = 0; got = 0; held_v = 1'b0; bp_seen = 1'b0; held_d = '0; held_t = '0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      sb.out_ready = !(cyc >= 3 && cyc <= 5);
      if (issued < 6) drive_main(1'b1, st_op[issued], st_src[issued], st_sh[issued], st_tag[issued]);
      else drive_main(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
      #1;
      if (held_v && sb.out_valid) begin
        check("stall_data_stable", sb.out_data, held_d);
        check("stall_tag_stable", 32'(sb.out_tag), 32'(held_t));
      end
      if (sb.in_valid && !sb.in_ready && !bp_seen) begin
        check("bp_buffered", 32'(issued - got), 32'd2);
        bp_seen = 1'b1;
      end
      if (sb.out_valid && sb.out_ready) begin
        check($sformatf("stall_op%0d_data", got), sb.out_data, model(st_op[got], st_src[got], st_sh[got]));
        check($sformatf("stall_op%0d_tag", got), 32'(sb.out_tag), 32'(st_tag[got]));
        got++;
      end
      held_v = sb.out_valid && !sb.out_ready;
      held_d = sb.out_data;
      held_t = sb.out_tag;
      if (sb.in_valid && sb.in_ready) issued++;
      tick();
    end
    check("stall_all_delivered", 32'(got), 32'd6);
    check("stall_backpressure_seen", 32'(bp_seen), 32'd1);
    drive_main(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
    sb.out_ready = 1'b1;
    tick();

    // Flush with two ops in flight
    drive_main(1'b1, 3'd0, 32'h00000001, 5'd1, 5'd7);
    tick();
    drive_main(1'b1, 3'd0, 32'h00000002, 5'd1, 5'd8);
    tick();
    check("flush_pre_valid", 32'(sb.out_valid), 32'd1);
    sb.flush = 1'b1; sb.out_ready = 1'b0;
    drive_main(1'b1, 3'd1, 32'h00000100, 5'd2, 5'd9);
    #1;
    check("flush_in_ready", 32'(sb.in_ready), 32'd0);
    tick();
    check("flush_out_valid", 32'(sb.out_valid), 32'd0);
    sb.flush = 1'b0; sb.out_ready = 1'b1;
    drive_main(1'b1, 3'b100, 32'h000000F0, 5'd4, 5'd10);
    #1;
    check("post_flush_in_ready", 32'(sb.in_ready), 32'd1);
    tick();
    drive_main(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
    check("post_flush_lat", 32'(sb.out_valid), 32'd0);
    tick();
    check_out("post_flush", 32'h0000000F, 5'd10);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush_no_ghost", 32'(sb.out_valid), 32'd0);
    end

    // Asynchronous reset mid-stream
    drive_main(1'b1, 3'd0, 32'h00000003, 5'd2, 5'd11);
    tick();
    drive_main(1'b1, 3'd0, 32'h00000005, 5'd2, 5'd12);
    tick();
    check_out("pre_rst", 32'h0000000C, 5'd11);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(sb.out_valid), 32'd0);
    check("async_rst_out_data", sb.out_data, 32'd0);
    check("async_rst_in_ready", 32'(sb.in_ready), 32'd0);
    drive_main(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_out_data", sb.out_data, 32'd0);
    check("post_rst_out_tag", 32'(sb.out_tag), 32'd0);
    check("post_rst_out_valid", 32'(sb.out_valid), 32'd0);
    drive_main(1'b1, 3'b010, 32'h80000010, 5'd4, 5'd12);
    tick();
    drive_main(1'b0, 3'd0, 32'd0, 5'd0, 5'd0);
    tick();
    check_out("post_rst_op", 32'hF8000001, 5'd12);

    // Random sweep on STAGES=1/3/5 against the behavioural model
    for (int cyc = 0; cyc < 320; cyc++) begin
      w_valid = (cyc < 300) && ($urandom_range(0, 3) != 0);
      w_op    = 3'($urandom_range(0, 7));
      w_src   = $urandom;
      w_sh    = 5'($urandom_range(0, 31));
      w_tag   = 5'($urandom_range(0, 31));
      sweep_drive();
      #1;
      sweep_chk(1, s1.out_valid, s1.out_data, s1.out_tag, s1.in_ready);
      sweep_chk(3, s3.out_valid, s3.out_data, s3.out_tag, s3.in_ready);
      sweep_chk(5, s5.out_valid, s5.out_data, s5.out_tag, s5.in_ready);
      tick();
    end
    check("sweep_s1_drained", 32'(q1.size()), 32'd0);
    check("sweep_s3_drained", 32'(q3.size()), 32'd0);
    check("sweep_s5_drained", 32'(q5.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
